// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32-subset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_control_opclass.sv
// mc_opclass: one-hot classification of the 7-bit opcode; illegal when no class matches.
// Latency: combinational.
// Backpressure: none.
module mc_opclass
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_alu_r,
    output logic       is_alu_i,
    output logic       illegal
);

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_alu_r  = 1'b0;
        is_alu_i  = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LOAD:   is_load   = 1'b1;
            OP_STORE:  is_store  = 1'b1;
            OP_BRANCH: is_branch = 1'b1;
            OP_RTYPE:  is_alu_r  = 1'b1;
            OP_ITYPE:  is_alu_i  = 1'b1;
            default:   illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH-DECODE-EXEC-MEM-WB sequencer; MULTICYCLE_PERF_EN adds perf_cycles/perf_instret.
// Latency: beq 3+A, R/I-type 4+A, sw 4+2A, lw 5+2A cycles (A = cycles waiting for mem_ack).
// Backpressure: mem_req held until mem_ack; MEM_TIMEOUT unacknowledged cycles park the core in TRAP.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_oper,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             trap,
`ifdef MULTICYCLE_PERF_EN
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_instret,
`endif
    output logic [1:0]       trap_cause
);

    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state;
    logic          started;
    logic          fetch_pend;
    logic [TW-1:0] tmo_cnt;

    logic is_load, is_store, is_branch, is_alu_r, is_alu_i, illegal;
    logic fetch_req, wait_cyc, tmo_hit;
    logic unused_instr;

    assign unused_instr = ^instr[31:7];

    mc_opclass u_opclass (
        .opcode    (instr[6:0]),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_alu_r  (is_alu_r),
        .is_alu_i  (is_alu_i),
        .illegal   (illegal)
    );

    // started keeps FETCH quiet while reset is held, even with run=1;
    // fetch_pend keeps an issued fetch request alive if run drops before the ack.
    assign fetch_req = (state == FETCH) && started && (run || fetch_pend);
    assign wait_cyc  = mem_req && !mem_ack;
    assign tmo_hit   = (MEM_TIMEOUT != 0) && wait_cyc && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            started    <= 1'b0;
            fetch_pend <= 1'b0;
            tmo_cnt    <= '0;
            trap_cause <= CAUSE_NONE;
        end else begin
            started    <= 1'b1;
            fetch_pend <= (state == FETCH) && wait_cyc;
            tmo_cnt    <= (wait_cyc && MEM_TIMEOUT != 0) ? tmo_cnt + 1'b1 : '0;
            case (state)
                FETCH: begin
                    if (tmo_hit) begin
                        state      <= TRAP;
                        trap_cause <= CAUSE_TIMEOUT;
                    end else if (fetch_req && mem_ack) begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (illegal) begin
                        state      <= TRAP;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_load || is_store)
                        state <= MEM;
                    else if (is_alu_r || is_alu_i)
                        state <= WB;
                    else
                        state <= FETCH;
                end
                MEM: begin
                    if (tmo_hit) begin
                        state      <= TRAP;
                        trap_cause <= CAUSE_TIMEOUT;
                    end else if (mem_ack) begin
                        state <= is_load ? WB : FETCH;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // State decode; ir_write/pc_write/instr_done additionally qualify on mem_ack/alu_zero.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_iord   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_oper   = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = fetch_req;
                ir_write = fetch_req && mem_ack;
                pc_write = fetch_req && mem_ack;
            end
            EXEC: begin
                if (is_load || is_store) begin
                    alu_src  = 1'b1;
                    alu_oper = ALU_ADD;
                end
                if (is_branch) begin
                    alu_oper   = ALU_SUB;
                    pc_src     = 1'b1;
                    pc_write   = alu_zero;
                    instr_done = 1'b1;
                end
                if (is_alu_r)
                    alu_oper = ALU_FUNC;
                if (is_alu_i) begin
                    alu_src  = 1'b1;
                    alu_oper = ALU_FUNC;
                end
            end
            MEM: begin
                mem_req    = 1'b1;
                mem_iord   = 1'b1;
                mem_we     = is_store;
                instr_done = is_store && mem_ack;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap = (state == TRAP);

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles  <= '0;
            perf_instret <= '0;
        end else begin
            if (state != TRAP)
                perf_cycles <= perf_cycles + 1'b1;
            if (instr_done)
                perf_instret <= perf_instret + 1'b1;
        end
    end
`else
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vector checked against hand-derived values.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_iord, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_oper;
    logic        reg_write, mem_to_reg, instr_done, trap;
    logic [1:0]  trap_cause;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .instr        (instr),
        .alu_zero     (alu_zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_iord     (mem_iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src      (alu_src),
        .alu_oper     (alu_oper),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .instr_done   (instr_done),
        .trap         (trap),
`ifdef MULTICYCLE_PERF_EN
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret),
`endif
        .trap_cause   (trap_cause)
    );

    // {req, we, iord, ir_write, pc_write, pc_src, alu_src, alu_oper[1:0], reg_write, mem_to_reg, done, trap, cause[1:0]}
    logic [14:0] ctl;
    assign ctl = {mem_req, mem_we, mem_iord, ir_write, pc_write, pc_src, alu_src,
                  alu_oper, reg_write, mem_to_reg, instr_done, trap, trap_cause};

    localparam logic [14:0] NONE  = 15'h0000;
    localparam logic [14:0] REQ   = 15'h4000;
    localparam logic [14:0] WE    = 15'h2000;
    localparam logic [14:0] IORD  = 15'h1000;
    localparam logic [14:0] IRW   = 15'h0800;
    localparam logic [14:0] PCW   = 15'h0400;
    localparam logic [14:0] PCS   = 15'h0200;
    localparam logic [14:0] ASRC  = 15'h0100;
    localparam logic [14:0] OFUNC = 15'h0080;
    localparam logic [14:0] OSUB  = 15'h0040;
    localparam logic [14:0] RW    = 15'h0020;
    localparam logic [14:0] M2R   = 15'h0010;
    localparam logic [14:0] DONE  = 15'h0008;
    localparam logic [14:0] TRP   = 15'h0004;
    localparam logic [14:0] C_ILL = 15'h0001;
    localparam logic [14:0] C_TMO = 15'h0002;
    localparam logic [14:0] FDONE = REQ | IRW | PCW;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: ctl=%h expected %h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; drives inputs, samples at posedge+2, returns at next posedge+1.
    task automatic cyc(input string tag, input logic ack, input logic z, input logic [14:0] exp);
        mem_ack  = ack;
        alu_zero = z;
        #1;
        check(tag, ctl, exp);
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        alu_zero = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_rst"}, ctl, NONE);
        run = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_post"}, ctl, NONE);
        run = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        run      = 1'b0;
        instr    = 32'h0;
        alu_zero = 1'b0;
        mem_ack  = 1'b0;
        #12;
        run = 1'b1;
        #1;
        check("reset_run1", ctl, NONE);
        run = 1'b0;
        #4;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_run0", ctl, NONE);
        run = 1'b1;

        instr = I_ADD;
        cyc("add_f", 1'b1, 1'b0, FDONE);
        cyc("add_d", 1'b0, 1'b0, NONE);
        cyc("add_e", 1'b0, 1'b0, OFUNC);
        cyc("add_w", 1'b0, 1'b0, RW | DONE);

        instr = I_LW;
        cyc("lw_f1", 1'b0, 1'b0, REQ);
        cyc("lw_f2", 1'b0, 1'b0, REQ);
        cyc("lw_f3", 1'b1, 1'b0, FDONE);
        cyc("lw_d",  1'b0, 1'b0, NONE);
        cyc("lw_e",  1'b0, 1'b0, ASRC);
        cyc("lw_m1", 1'b0, 1'b0, REQ | IORD);
        cyc("lw_m2", 1'b0, 1'b0, REQ | IORD);
        cyc("lw_m3", 1'b1, 1'b0, REQ | IORD);
        cyc("lw_w",  1'b0, 1'b0, RW | M2R | DONE);

        instr = I_BEQ;
        cyc("beq1_f", 1'b1, 1'b0, FDONE);
        cyc("beq1_d", 1'b0, 1'b0, NONE);
        cyc("beq1_e", 1'b0, 1'b1, OSUB | PCW | PCS | DONE);
        cyc("beq0_f", 1'b1, 1'b0, FDONE);
        cyc("beq0_d", 1'b0, 1'b0, NONE);
        cyc("beq0_e", 1'b0, 1'b0, OSUB | PCS | DONE);
        cyc("beq0_ret", 1'b0, 1'b0, REQ);

        instr = I_ADDI;
        cyc("addi_f", 1'b1, 1'b0, FDONE);
        cyc("addi_d", 1'b0, 1'b0, NONE);
        cyc("addi_e", 1'b0, 1'b0, ASRC | OFUNC);
        cyc("addi_w", 1'b0, 1'b0, RW | DONE);

        instr = I_SW;
        cyc("sw_f", 1'b1, 1'b0, FDONE);
        cyc("sw_d", 1'b0, 1'b0, NONE);
        cyc("sw_e", 1'b0, 1'b0, ASRC);
        cyc("sw_m", 1'b1, 1'b0, REQ | WE | IORD | DONE);

        cyc("swr_f", 1'b1, 1'b0, FDONE);
        cyc("swr_d", 1'b0, 1'b0, NONE);
        cyc("swr_e", 1'b0, 1'b0, ASRC);
        #1;
        check("swr_m", ctl, REQ | WE | IORD);
        do_reset("swr");

        instr = I_LW;
        cyc("tmo_f",  1'b1, 1'b0, FDONE);
        cyc("tmo_d",  1'b0, 1'b0, NONE);
        cyc("tmo_e",  1'b0, 1'b0, ASRC);
        cyc("tmo_m1", 1'b0, 1'b0, REQ | IORD);
        cyc("tmo_m2", 1'b0, 1'b0, REQ | IORD);
        cyc("tmo_m3", 1'b0, 1'b0, REQ | IORD);
        cyc("tmo_m4", 1'b0, 1'b0, REQ | IORD);
        cyc("tmo_trap1", 1'b0, 1'b0, TRP | C_TMO);
        cyc("tmo_trap2", 1'b1, 1'b0, TRP | C_TMO);
        do_reset("tmo");

        cyc("ack4_f",  1'b1, 1'b0, FDONE);
        cyc("ack4_d",  1'b0, 1'b0, NONE);
        cyc("ack4_e",  1'b0, 1'b0, ASRC);
        cyc("ack4_m1", 1'b0, 1'b0, REQ | IORD);
        cyc("ack4_m2", 1'b0, 1'b0, REQ | IORD);
        cyc("ack4_m3", 1'b0, 1'b0, REQ | IORD);
        cyc("ack4_m4", 1'b1, 1'b0, REQ | IORD);
        cyc("ack4_w",  1'b0, 1'b0, RW | M2R | DONE);

        instr = I_BAD;
        cyc("ill_f", 1'b1, 1'b0, FDONE);
        cyc("ill_d", 1'b0, 1'b0, NONE);
        cyc("ill_trap1", 1'b1, 1'b0, TRP | C_ILL);
        cyc("ill_trap2", 1'b1, 1'b1, TRP | C_ILL);
        cyc("ill_trap3", 1'b0, 1'b0, TRP | C_ILL);
        do_reset("ill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
